// File: rtl/ppfifo_rd_stream_if.sv
// Stream side of the ping-pong FIFO read controller: valid/ready words with an end-of-buffer flag.
interface ppfifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  axis_valid;
    logic                  axis_ready;
    logic [DATA_WIDTH-1:0] axis_data;
    logic                  axis_last;

    modport master (
        output axis_valid,
        output axis_data,
        output axis_last,
        input  axis_ready
    );

    modport slave (
        input  axis_valid,
        input  axis_data,
        input  axis_last,
        output axis_ready
    );
endinterface

// File: rtl/ppfifo_rd_stream.sv
// Read-side controller for the ping-pong FIFO: claims a filled buffer, pops it through a two-entry
// skid buffer and streams it out. Define PPFIFO_RD_LAST_EN to carry an end-of-buffer flag on the stream.
module ppfifo_rd_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_rd_rdy,
    output logic                  o_rd_act,
    input  logic [15:0]           i_rd_size,
    output logic                  o_rd_stb,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    ppfifo_rd_stream_if.master    m_axis,
    output logic                  o_busy
);

`ifdef PPFIFO_RD_LAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACTIVATE = 3'd1,
        ST_READ     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_act_phase;
    logic                 w_act_phase_nxt;
    logic                 r_rd_act;
    logic [15:0]          r_remaining;
    logic [15:0]          w_remaining_nxt;
    logic                 r_inflight;
    logic [1:0]           r_count;
    logic [ENTRY_W-1:0]   r_e0;
    logic [ENTRY_W-1:0]   r_e1;
    logic [ENTRY_W-1:0]   w_in_entry;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_occ;
    logic                 w_stb;
    logic                 w_drain_done;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && m_axis.axis_ready;
    assign w_push  = r_inflight;
    // Occupancy the skid will have once this cycle's pop and the word already in flight settle.
    assign w_occ        = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_stb        = (r_state == ST_READ) && (r_remaining != 16'd0) && (w_occ < 2'd2);
    assign w_drain_done = !r_inflight && ((r_count - {1'b0, w_pop}) == 2'd0);

    assign o_rd_stb          = w_stb;
    assign o_rd_act          = r_rd_act;
    assign o_busy            = (r_state != ST_IDLE);
    assign m_axis.axis_valid = w_valid;
    assign m_axis.axis_data  = r_e0[DATA_WIDTH-1:0];

`ifdef PPFIFO_RD_LAST_EN
    logic r_inflight_last;

    assign w_in_entry        = {r_inflight_last, i_rd_data};
    assign m_axis.axis_last  = r_e0[DATA_WIDTH] & w_valid;

    // Tag the in-flight word when its strobe empties the remaining counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight_last <= w_stb && (r_remaining == 16'd1);
        end
    end
`else
    assign w_in_entry        = i_rd_data;
    assign m_axis.axis_last  = 1'b0;
`endif

    // Next-state logic; ACTIVATE spends one cycle announcing the claim before sampling the size.
    always_comb begin
        w_state_nxt     = r_state;
        w_act_phase_nxt = 1'b0;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_rd_rdy) begin
                    w_state_nxt = ST_ACTIVATE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVATE: begin
                if (!r_act_phase) begin
                    w_act_phase_nxt = 1'b1;
                end else begin
                    w_remaining_nxt = i_rd_size;
                    if (i_rd_size == 16'd0) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (w_stb) begin
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, claim flag and remaining-word counter; o_rd_act stays high from ACTIVATE through DRAIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_act_phase <= 1'b0;
            r_rd_act    <= 1'b0;
            r_remaining <= 16'd0;
            r_inflight  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_act_phase <= w_act_phase_nxt;
            r_rd_act    <= (w_state_nxt == ST_ACTIVATE) || (w_state_nxt == ST_READ) ||
                           (w_state_nxt == ST_DRAIN);
            r_remaining <= w_remaining_nxt;
            r_inflight  <= w_stb;
        end
    end

    // Skid buffer: entry 0 is the stream head, entry 1 holds the word queued behind it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 2'd0;
            r_e0    <= '0;
            r_e1    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_e0 <= w_in_entry;
                    end else begin
                        r_e1 <= w_in_entry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0 <= w_in_entry;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= w_in_entry;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppfifo_rd_stream.sv
// Bench for ppfifo_rd_stream: a FIFO source model feeds buffers, a stream model predicts valid/data/last.
module tb_ppfifo_rd_stream;

`ifdef PPFIFO_RD_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rd_rdy;
    logic        rd_act;
    logic [15:0] rd_size;
    logic        rd_stb;
    logic [31:0] rd_data;
    logic        busy;

    ppfifo_rd_stream_if #(.DATA_WIDTH(32)) axis_if ();

    ppfifo_rd_stream #(.DATA_WIDTH(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (enable),
        .i_rd_rdy  (rd_rdy),
        .o_rd_act  (rd_act),
        .i_rd_size (rd_size),
        .o_rd_stb  (rd_stb),
        .i_rd_data (rd_data),
        .m_axis    (axis_if),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // FIFO source model
    int buf_q[$];
    int tag_q[$];
    int cur_size = 0, cur_tag = 0, cur_idx = 0;
    bit claimed = 1'b0;
    bit stb_pend = 1'b0;
    logic [31:0] pend_word = 32'd0;

    // stream model
    word_t exp_q[$];
    int m_stb = 0, m_acc = 0, m_p1 = 0, m_p2 = 0;

    bit rdy_rand = 1'b0;
    logic [31:0] rdy_pat = 32'hA5C3_96E1;

    // per-test statistics
    int st_act_rise, st_act_fall, st_act_hi, st_rises, st_min_gap;
    int st_first_stb, st_last_stb, st_stb;
    int st_first_valid, st_valid, st_acc, st_last, st_last_acc;

    function automatic logic [31:0] word_of(input int tag, input int idx);
        logic [31:0] t, i;
        t = tag;
        i = idx;
        return {t[15:0], i[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic reset_stats();
        st_act_rise = -1; st_act_fall = -1; st_act_hi = 0; st_rises = 0; st_min_gap = 1000;
        st_first_stb = -1; st_last_stb = -1; st_stb = 0;
        st_first_valid = -1; st_valid = 0; st_acc = 0; st_last = 0; st_last_acc = -1;
    endtask

    task automatic push_buf(input int sz, input int tag);
        buf_q.push_back(sz);
        tag_q.push_back(tag);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((buf_q.size() != 0 || claimed || busy) && n < budget);
        chk({"done_within_budget_", nm}, n < budget, 1'b1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_act"},   rd_act, 1'b0);
        chk({nm, "_stb"},   rd_stb, 1'b0);
        chk({nm, "_valid"}, axis_if.axis_valid, 1'b0);
        chk({nm, "_last"},  axis_if.axis_last, 1'b0);
        chk({nm, "_data"},  axis_if.axis_data, 32'd0);
        chk({nm, "_busy"},  busy, 1'b0);
    endtask

    // Input driver: FIFO read data one cycle after a strobe, ready pattern, rdy/size.
    always @(posedge clk) begin
        #1;
        if (stb_pend) begin
            rd_data  = pend_word;
            stb_pend = 1'b0;
        end
        axis_if.axis_ready = rdy_rand ? rdy_pat[cyc % 32] : 1'b1;
        rd_rdy  = (buf_q.size() != 0);
        rd_size = claimed ? cur_size[15:0] : 16'd0;
    end

    // Compare process: FIFO claim bookkeeping and stream checks against the model.
    always @(negedge clk) begin
        bit exp_valid;
        word_t w;
        if (!rst_n) begin
            chk_outputs_zero("in_reset");
            m_stb = 0; m_acc = 0; m_p1 = 0; m_p2 = 0;
            exp_q.delete();
            claimed  = 1'b0;
            stb_pend = 1'b0;
        end else begin
            exp_valid = (m_p2 > m_acc);
            if (rd_act && !claimed) begin
                chk("act_has_buffer", buf_q.size() != 0, 1'b1);
                claimed = 1'b1;
                cur_idx = 0;
                cur_size = (buf_q.size() != 0) ? buf_q.pop_front() : 0;
                cur_tag  = (tag_q.size() != 0) ? tag_q.pop_front() : 0;
                for (int i = 0; i < cur_size; i++) begin
                    w.d = word_of(cur_tag, i);
                    w.l = LAST_EN && (i == cur_size - 1);
                    exp_q.push_back(w);
                end
                st_rises++;
                if (st_act_rise < 0) st_act_rise = cyc;
                if (st_act_fall >= 0 && (cyc - st_act_fall) < st_min_gap) st_min_gap = cyc - st_act_fall;
            end else if (!rd_act && claimed) begin
                claimed = 1'b0;
                st_act_fall = cyc;
                chk("strobes_per_buffer", cur_idx, cur_size);
            end
            if (rd_act) st_act_hi++;

            if (rd_stb) begin
                chk("stb_within_buffer", claimed && (cur_idx < cur_size), 1'b1);
                pend_word = word_of(cur_tag, cur_idx);
                cur_idx++;
                stb_pend = 1'b1;
                m_stb++;
                st_stb++;
                if (st_first_stb < 0) st_first_stb = cyc;
                st_last_stb = cyc;
            end

            chk("valid", axis_if.axis_valid, exp_valid);
            if (axis_if.axis_valid) begin
                st_valid++;
                if (st_first_valid < 0) st_first_valid = cyc;
            end
            if (axis_if.axis_valid && axis_if.axis_ready) begin
                chk("stream_word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("data", axis_if.axis_data, w.d);
                    chk("last", axis_if.axis_last, w.l);
                end
                m_acc++;
                st_acc++;
                st_last_acc = cyc;
                if (axis_if.axis_last) st_last++;
            end
            chk("outstanding_le_2", (m_stb - m_acc) <= 2, 1'b1);
            m_p2 = m_p1;
            m_p1 = m_stb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int n;
        rst_n = 1'b0; enable = 1'b1; rd_rdy = 1'b0; rd_size = 16'd0; rd_data = 32'd0;
        axis_if.axis_ready = 1'b0;
        reset_stats();

        // reset held with a buffer waiting, then size 16 at full throughput
        push_buf(16, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        wait_done(200, "t1");
        chk("t1_act_latency",   st_act_rise - rel, 1);
        chk("t1_stb_latency",   st_first_stb - st_act_rise, 2);
        chk("t1_valid_latency", st_first_valid - st_first_stb, 2);
        chk("t1_stb_count",     st_stb, 16);
        chk("t1_stb_span",      st_last_stb - st_first_stb, 15);
        chk("t1_valid_cycles",  st_valid, 16);
        chk("t1_words",         st_acc, 16);
        chk("t1_last_count",    st_last, LAST_EN ? 1 : 0);
        chk("t1_act_fall",      st_act_fall - st_last_acc, 1);

        // size 16 with a stalling consumer
        reset_stats();
        rdy_rand = 1'b1;
        push_buf(16, 1);
        wait_done(400, "t2");
        chk("t2_stb_count",  st_stb, 16);
        chk("t2_words",      st_acc, 16);
        chk("t2_last_count", st_last, LAST_EN ? 1 : 0);
        rdy_rand = 1'b0;

        // enable low blocks the claim; then size 0
        reset_stats();
        enable = 1'b0;
        push_buf(0, 2);
        repeat (6) @(posedge clk);
        #2;
        chk("t3_enable_low_no_claim", st_act_hi, 0);
        enable = 1'b1;
        wait_done(100, "t3");
        chk("t3_act_cycles",   st_act_hi, 2);
        chk("t3_stb_count",    st_stb, 0);
        chk("t3_valid_cycles", st_valid, 0);

        // back-to-back buffers of 3 and 5 words
        reset_stats();
        push_buf(3, 3);
        push_buf(5, 4);
        wait_done(300, "t4");
        chk("t4_words",      st_acc, 8);
        chk("t4_last_count", st_last, LAST_EN ? 2 : 0);
        chk("t4_act_rises",  st_rises, 2);
        chk("t4_act_gap_ge_1", st_min_gap >= 1, 1'b1);

        // reset after word 7 of 16, then a fresh size-4 buffer
        reset_stats();
        push_buf(16, 5);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (st_acc < 7 && n < 200);
        chk("t5_reached_word_7", st_acc >= 7, 1'b1);
        #1 rst_n = 1'b0;
        buf_q.delete();
        tag_q.delete();
        claimed = 1'b0;
        #1 chk_outputs_zero("t5_async_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        reset_stats();
        push_buf(4, 6);
        wait_done(200, "t5");
        chk("t5_words",      st_acc, 4);
        chk("t5_stb_count",  st_stb, 4);
        chk("t5_last_count", st_last, LAST_EN ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
